// File: rtl/cv32e40p_ft_pkg.sv
// Shared types and constants for the fault-tolerant test wrapper blocks.
// The fault injector uses its state encoding, LFSR polynomial and
// replica rotation helper from here.
package cv32e40p_ft_pkg;

    // Fault injector sequencing states
    typedef enum logic [1:0] {
        FINJ_IDLE   = 2'd0,
        FINJ_DELAY  = 2'd1,
        FINJ_INJECT = 2'd2,
        FINJ_GAP    = 2'd3
    } finj_state_e;

    // Galois right-shift tap mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] FINJ_LFSR_POLY = 32'h8020_0003;

    // Replica selector value meaning "rotate 0,1,2,0..."
    localparam logic [1:0] FINJ_REPLICA_ROTATE = 2'd3;

    // Next replica in the rotation sequence 0 -> 1 -> 2 -> 0
    function automatic logic [1:0] finj_rotate_next(input logic [1:0] cur);
        logic [1:0] nxt;
        case (cur)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/cv32e40p_ft_lfsr.sv
// Free-running Galois LFSR. Only the low OUT_W bits are exported because
// consumers use the state as a small random index.
module cv32e40p_ft_lfsr
    import cv32e40p_ft_pkg::*;
#(
    parameter int unsigned     WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY = FINJ_LFSR_POLY,
    parameter logic [WIDTH-1:0] SEED = 32'hACE1_2468,
    parameter int unsigned     OUT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [OUT_W-1:0] value
);

    logic [WIDTH-1:0] state_r;

    // Shift right; when a one falls out of bit 0, fold in the tap mask
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= SEED;
        end else if (en) begin
            state_r <= {1'b0, state_r[WIDTH-1:1]} ^ (state_r[0] ? POLY : {WIDTH{1'b0}});
        end else begin
            state_r <= state_r;
        end
    end

    assign value = state_r[OUT_W-1:0];

endmodule

// File: rtl/cv32e40p_ft_fault_injector.sv
// Programmable per-replica bit-flip generator for the triplicated outputs
// of a fault-tolerant unit. It corrupts at most one replica per cycle so
// the downstream voter always has a clean majority, while still driving
// its error flag and the breakage counters through their ranges.
module cv32e40p_ft_fault_injector
    import cv32e40p_ft_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DELAY_BIT = 16,
    parameter int unsigned COUNT_BIT = 8,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [1:0]           cfg_replica_i,
    input  logic [WIDTH-1:0]     cfg_mask_i,
    input  logic [DELAY_BIT-1:0] cfg_delay_i,
    input  logic [COUNT_BIT-1:0] cfg_duration_i,
    input  logic [COUNT_BIT-1:0] cfg_repeat_i,
    input  logic [DELAY_BIT-1:0] cfg_gap_i,
    input  logic                 abort_i,
    output logic [3*WIDTH-1:0]   flip_mask_o,
    output logic                 active_o,
    output logic                 done_o,
    output logic [COUNT_BIT-1:0] inj_count_o
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    localparam logic [DELAY_BIT-1:0] DLY_ZERO  = {DELAY_BIT{1'b0}};
    localparam logic [DELAY_BIT-1:0] DLY_ONE   = {{(DELAY_BIT-1){1'b0}}, 1'b1};
    localparam logic [COUNT_BIT-1:0] CNT_ZERO  = {COUNT_BIT{1'b0}};
    localparam logic [COUNT_BIT-1:0] CNT_ONE   = {{(COUNT_BIT-1){1'b0}}, 1'b1};
    localparam logic [COUNT_BIT-1:0] CNT_MAX   = {COUNT_BIT{1'b1}};
    localparam logic [WIDTH-1:0]     MASK_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]     MASK_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [3*WIDTH-1:0]   FLIP_ZERO = {(3*WIDTH){1'b0}};

    // Sequencer state and latched configuration
    finj_state_e          state_r;
    logic [WIDTH-1:0]     cfg_mask_r;
    logic [1:0]           cfg_replica_r;
    logic [COUNT_BIT-1:0] cfg_duration_r;
    logic [COUNT_BIT-1:0] cfg_repeat_r;
    logic [DELAY_BIT-1:0] cfg_gap_r;

    // Counters and registered outputs
    logic [DELAY_BIT-1:0] delay_cnt_r;
    logic [DELAY_BIT-1:0] gap_cnt_r;
    logic [COUNT_BIT-1:0] dur_cnt_r;
    logic [COUNT_BIT-1:0] rep_cnt_r;
    logic [COUNT_BIT-1:0] inj_count_r;
    logic [1:0]           rot_r;
    logic [3*WIDTH-1:0]   flip_r;
    logic                 active_r;
    logic                 done_r;

    // Decoded control and next-injection values
    logic [IDX_W-1:0]     lfsr_idx_s;
    logic                 accept_s;
    logic                 abort_s;
    logic                 last_s;
    logic                 enter_inj_s;
    logic [WIDTH-1:0]     eff_mask_s;
    logic [1:0]           eff_replica_s;
    logic [COUNT_BIT-1:0] eff_duration_s;
    logic [1:0]           rot_cur_s;
    logic [COUNT_BIT-1:0] rep_cur_s;
    logic [COUNT_BIT-1:0] inj_cur_s;
    logic [1:0]           target_s;
    logic [1:0]           rot_after_s;
    logic [WIDTH-1:0]     mask_s;
    logic [COUNT_BIT-1:0] dur_load_s;
    logic [COUNT_BIT-1:0] rep_inc_s;
    logic [COUNT_BIT-1:0] inj_inc_s;
    logic [3*WIDTH-1:0]   flip_s;

    cv32e40p_ft_lfsr #(
        .WIDTH (32),
        .POLY  (FINJ_LFSR_POLY),
        .SEED  (LFSR_SEED),
        .OUT_W (IDX_W)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .value (lfsr_idx_s)
    );

    // Ready only when idle and not being reset
    assign cfg_ready_o = (state_r == FINJ_IDLE) & ~rst;

    // Values loaded on entry to INJECT; at accept time the fresh inputs are used
    always_comb begin
        accept_s       = cfg_valid_i & cfg_ready_o;
        abort_s        = abort_i & (state_r != FINJ_IDLE);
        last_s         = (cfg_repeat_r != CNT_ZERO) & (rep_cnt_r == cfg_repeat_r);
        eff_mask_s     = accept_s ? cfg_mask_i     : cfg_mask_r;
        eff_replica_s  = accept_s ? cfg_replica_i  : cfg_replica_r;
        eff_duration_s = accept_s ? cfg_duration_i : cfg_duration_r;
        rot_cur_s      = accept_s ? 2'd0           : rot_r;
        rep_cur_s      = accept_s ? CNT_ZERO       : rep_cnt_r;
        inj_cur_s      = accept_s ? CNT_ZERO       : inj_count_r;
        target_s       = (eff_replica_s == FINJ_REPLICA_ROTATE) ? rot_cur_s : eff_replica_s;
        rot_after_s    = (eff_replica_s == FINJ_REPLICA_ROTATE) ? finj_rotate_next(rot_cur_s) : rot_cur_s;
        mask_s         = (eff_mask_s != MASK_ZERO) ? eff_mask_s : (MASK_ONE << lfsr_idx_s);
        dur_load_s     = (eff_duration_s == CNT_ZERO) ? CNT_ONE : eff_duration_s;
        inj_inc_s      = (inj_cur_s == CNT_MAX) ? CNT_MAX : inj_cur_s + CNT_ONE;
        rep_inc_s      = (rep_cur_s == CNT_MAX) ? CNT_MAX : rep_cur_s + CNT_ONE;
        flip_s         = FLIP_ZERO;
        case (target_s)
            2'd0:    flip_s[0*WIDTH +: WIDTH] = mask_s;
            2'd1:    flip_s[1*WIDTH +: WIDTH] = mask_s;
            2'd2:    flip_s[2*WIDTH +: WIDTH] = mask_s;
            default: flip_s = FLIP_ZERO;
        endcase
    end

    // Decide whether the coming edge starts a new injection
    always_comb begin
        enter_inj_s = 1'b0;
        case (state_r)
            FINJ_IDLE:   enter_inj_s = accept_s & (cfg_delay_i == DLY_ZERO);
            FINJ_DELAY:  enter_inj_s = ~abort_i & (delay_cnt_r <= DLY_ONE);
            FINJ_INJECT: enter_inj_s = ~abort_i & (dur_cnt_r <= CNT_ONE) & ~last_s & (cfg_gap_r == DLY_ZERO);
            FINJ_GAP:    enter_inj_s = ~abort_i & (gap_cnt_r <= DLY_ONE);
            default:     enter_inj_s = 1'b0;
        endcase
    end

    // Sequencer: state, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= FINJ_IDLE;
            cfg_mask_r     <= MASK_ZERO;
            cfg_replica_r  <= 2'd0;
            cfg_duration_r <= CNT_ZERO;
            cfg_repeat_r   <= CNT_ZERO;
            cfg_gap_r      <= DLY_ZERO;
            delay_cnt_r    <= DLY_ZERO;
            gap_cnt_r      <= DLY_ZERO;
            dur_cnt_r      <= CNT_ZERO;
            rep_cnt_r      <= CNT_ZERO;
            inj_count_r    <= CNT_ZERO;
            rot_r          <= 2'd0;
            flip_r         <= FLIP_ZERO;
            active_r       <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (abort_s) begin
                // Abort drops everything but keeps the injection count visible
                state_r  <= FINJ_IDLE;
                flip_r   <= FLIP_ZERO;
                active_r <= 1'b0;
            end else begin
                case (state_r)
                    FINJ_IDLE: begin
                        if (accept_s) begin
                            cfg_mask_r     <= cfg_mask_i;
                            cfg_replica_r  <= cfg_replica_i;
                            cfg_duration_r <= cfg_duration_i;
                            cfg_repeat_r   <= cfg_repeat_i;
                            cfg_gap_r      <= cfg_gap_i;
                            inj_count_r    <= CNT_ZERO;
                            rep_cnt_r      <= CNT_ZERO;
                            rot_r          <= 2'd0;
                            if (cfg_delay_i != DLY_ZERO) begin
                                state_r     <= FINJ_DELAY;
                                delay_cnt_r <= cfg_delay_i;
                            end
                        end
                    end
                    FINJ_DELAY: begin
                        if (delay_cnt_r > DLY_ONE) begin
                            delay_cnt_r <= delay_cnt_r - DLY_ONE;
                        end
                    end
                    FINJ_INJECT: begin
                        if (dur_cnt_r > CNT_ONE) begin
                            dur_cnt_r <= dur_cnt_r - CNT_ONE;
                        end else if (last_s) begin
                            state_r  <= FINJ_IDLE;
                            flip_r   <= FLIP_ZERO;
                            active_r <= 1'b0;
                            done_r   <= 1'b1;
                        end else if (cfg_gap_r != DLY_ZERO) begin
                            state_r   <= FINJ_GAP;
                            gap_cnt_r <= cfg_gap_r;
                            flip_r    <= FLIP_ZERO;
                            active_r  <= 1'b0;
                        end
                    end
                    FINJ_GAP: begin
                        if (gap_cnt_r > DLY_ONE) begin
                            gap_cnt_r <= gap_cnt_r - DLY_ONE;
                        end
                    end
                    default: begin
                        state_r  <= FINJ_IDLE;
                        flip_r   <= FLIP_ZERO;
                        active_r <= 1'b0;
                    end
                endcase

                // A new injection overrides whatever the state branch chose
                if (enter_inj_s) begin
                    state_r     <= FINJ_INJECT;
                    flip_r      <= flip_s;
                    active_r    <= 1'b1;
                    dur_cnt_r   <= dur_load_s;
                    delay_cnt_r <= DLY_ZERO;
                    gap_cnt_r   <= DLY_ZERO;
                    inj_count_r <= inj_inc_s;
                    rep_cnt_r   <= rep_inc_s;
                    rot_r       <= rot_after_s;
                end
            end
        end
    end

    assign flip_mask_o = flip_r;
    assign active_o    = active_r;
    assign done_o      = done_r;
    assign inj_count_o = inj_count_r;

endmodule

// File: tb/tb_cv32e40p_ft_fault_injector.sv
// Scoreboard bench for the fault injector: each configuration pushes the
// injections and done pulse it must produce; a negedge monitor pops and
// compares whenever the injector shows activity.
module tb_cv32e40p_ft_fault_injector;

    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_replica = 2'd0;
    logic [31:0] cfg_mask = 32'h0;
    logic [15:0] cfg_delay = 16'h0;
    logic [7:0]  cfg_duration = 8'h0;
    logic [7:0]  cfg_repeat = 8'h0;
    logic [15:0] cfg_gap = 16'h0;
    logic        abort = 1'b0;
    logic [95:0] flip_mask;
    logic        active;
    logic        done;
    logic [7:0]  inj_count;

    cv32e40p_ft_fault_injector dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_valid_i    (cfg_valid),
        .cfg_ready_o    (cfg_ready),
        .cfg_replica_i  (cfg_replica),
        .cfg_mask_i     (cfg_mask),
        .cfg_delay_i    (cfg_delay),
        .cfg_duration_i (cfg_duration),
        .cfg_repeat_i   (cfg_repeat),
        .cfg_gap_i      (cfg_gap),
        .abort_i        (abort),
        .flip_mask_o    (flip_mask),
        .active_o       (active),
        .done_o         (done),
        .inj_count_o    (inj_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR written straight from the polynomial
    function automatic logic [31:0] ref_step(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ ((32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1);
        return n;
    endfunction

    logic [31:0] ref_lfsr = SEED;
    logic [31:0] ref_prev = SEED;
    always @(posedge clk) begin
        ref_prev <= ref_lfsr;
        if (rst) ref_lfsr <= SEED;
        else     ref_lfsr <= ref_step(ref_lfsr);
    end

    typedef struct {
        int          cyc;
        bit          is_done;
        logic [1:0]  rep;
        logic [31:0] mask;
        bit          rnd;
        logic [7:0]  cnt;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic push_inj(input int c, input logic [1:0] r, input logic [31:0] m, input bit rnd);
        exp_t e;
        e.cyc = c; e.is_done = 1'b0; e.rep = r; e.mask = m; e.rnd = rnd; e.cnt = 8'h0;
        q.push_back(e);
    endtask

    task automatic push_done(input int c, input logic [7:0] n);
        exp_t e;
        e.cyc = c; e.is_done = 1'b1; e.rep = 2'd0; e.mask = 32'h0; e.rnd = 1'b0; e.cnt = n;
        q.push_back(e);
    endtask

    // Monitor: pop one expectation per active/done cycle, otherwise masks must be clear
    exp_t        mon_e;
    logic [31:0] mon_m;
    logic [31:0] mon_one;
    logic [95:0] mon_flip;
    always @(negedge clk) begin
        if (active || done) begin
            if (q.size() == 0) begin
                chk("unexpected_activity", {94'h0, active, done}, 96'h0);
            end else begin
                mon_e = q.pop_front();
                chk("event_cycle", 96'(mon_e.cyc), 96'(cyc));
                if (mon_e.is_done) begin
                    chk("done_pulse", {95'h0, done}, 96'h1);
                    chk("done_count", {88'h0, inj_count}, {88'h0, mon_e.cnt});
                    chk("done_ready", {95'h0, cfg_ready}, 96'h1);
                end else begin
                    mon_one = 32'h1;
                    mon_m = mon_e.rnd ? (mon_one << ref_prev[4:0]) : mon_e.mask;
                    mon_flip = 96'h0;
                    mon_flip[mon_e.rep*32 +: 32] = mon_m;
                    chk("active", {95'h0, active}, 96'h1);
                    chk("flip_mask", flip_mask, mon_flip);
                end
            end
        end else begin
            chk("idle_mask_zero", flip_mask, 96'h0);
        end
    end

    task automatic start(input logic [1:0] r, input logic [31:0] m, input logic [15:0] d,
                         input logic [7:0] du, input logic [7:0] rp, input logic [15:0] g,
                         input bit with_abort, output int acc);
        @(posedge clk); #1;
        chk("ready_before_accept", {95'h0, cfg_ready}, 96'h1);
        cfg_replica = r; cfg_mask = m; cfg_delay = d;
        cfg_duration = du; cfg_repeat = rp; cfg_gap = g;
        cfg_valid = 1'b1; abort = with_abort;
        @(posedge clk); #1;
        acc = cyc;
        cfg_valid = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        int a;
        // Reset values while rst is high, then ready once released
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {95'h0, cfg_ready}, 96'h0);
        chk("rst_flip", flip_mask, 96'h0);
        chk("rst_active", {95'h0, active}, 96'h0);
        chk("rst_done", {95'h0, done}, 96'h0);
        chk("rst_count", {88'h0, inj_count}, 96'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {95'h0, cfg_ready}, 96'h1);

        // Single shot: replica 1, delay 3, duration 2
        start(2'd1, 32'h1, 16'd3, 8'd2, 8'd1, 16'd0, 1'b0, a);
        push_inj(a + 3, 2'd1, 32'h1, 1'b0);
        push_inj(a + 4, 2'd1, 32'h1, 1'b0);
        push_done(a + 5, 8'd1);
        wait_cyc(a + 8);

        // Rotate across replicas with gap 2
        start(2'd3, 32'hFFFF_0000, 16'd0, 8'd1, 8'd4, 16'd2, 1'b0, a);
        for (int k = 0; k < 4; k++) push_inj(a + 3 * k, 2'(k % 3), 32'hFFFF_0000, 1'b0);
        push_done(a + 10, 8'd4);
        wait_cyc(a + 13);

        // Back-to-back: duration 0, gap 0
        start(2'd2, 32'h8000_0001, 16'd0, 8'd0, 8'd3, 16'd0, 1'b0, a);
        for (int k = 0; k < 3; k++) push_inj(a + k, 2'd2, 32'h8000_0001, 1'b0);
        push_done(a + 3, 8'd3);
        wait_cyc(a + 6);

        // LFSR-chosen bit, rotating, delay 2, gap 1
        start(2'd3, 32'h0, 16'd2, 8'd1, 8'd5, 16'd1, 1'b0, a);
        for (int k = 0; k < 5; k++) push_inj(a + 2 + 2 * k, 2'(k % 3), 32'h0, 1'b1);
        push_done(a + 11, 8'd5);
        wait_cyc(a + 14);

        // Unbounded, aborted in the middle of the second injection
        start(2'd0, 32'h0F0F_0F0F, 16'd1, 8'd2, 8'd0, 16'd1, 1'b0, a);
        push_inj(a + 1, 2'd0, 32'h0F0F_0F0F, 1'b0);
        push_inj(a + 2, 2'd0, 32'h0F0F_0F0F, 1'b0);
        push_inj(a + 4, 2'd0, 32'h0F0F_0F0F, 1'b0);
        push_inj(a + 5, 2'd0, 32'h0F0F_0F0F, 1'b0);
        wait_cyc(a + 5);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_flip", flip_mask, 96'h0);
        chk("abort_active", {95'h0, active}, 96'h0);
        chk("abort_done", {95'h0, done}, 96'h0);
        chk("abort_count", {88'h0, inj_count}, 96'd2);
        chk("abort_ready", {95'h0, cfg_ready}, 96'h1);
        wait_cyc(a + 9);

        // Accept wins over simultaneous abort; count saturates at 255
        start(2'd2, 32'h0000_0100, 16'd0, 8'd0, 8'd0, 16'd0, 1'b1, a);
        for (int k = 0; k < 300; k++) push_inj(a + k, 2'd2, 32'h0000_0100, 1'b0);
        wait_cyc(a + 299);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("sat_count", {88'h0, inj_count}, 96'hFF);
        chk("sat_active", {95'h0, active}, 96'h0);
        chk("sat_ready", {95'h0, cfg_ready}, 96'h1);

        // Abort alone in idle is ignored
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_ready", {95'h0, cfg_ready}, 96'h1);
        chk("idle_abort_count", {88'h0, inj_count}, 96'hFF);

        // Reset during INJECT
        start(2'd1, 32'h0000_FFFF, 16'd0, 8'd4, 8'd1, 16'd0, 1'b0, a);
        push_inj(a, 2'd1, 32'h0000_FFFF, 1'b0);
        push_inj(a + 1, 2'd1, 32'h0000_FFFF, 1'b0);
        wait_cyc(a + 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_flip", flip_mask, 96'h0);
        chk("midrst_active", {95'h0, active}, 96'h0);
        chk("midrst_done", {95'h0, done}, 96'h0);
        chk("midrst_count", {88'h0, inj_count}, 96'h0);
        chk("midrst_ready", {95'h0, cfg_ready}, 96'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("postrst_ready", {95'h0, cfg_ready}, 96'h1);
        chk("postrst_active", {95'h0, active}, 96'h0);
        repeat (4) @(posedge clk);
        @(negedge clk);

        chk("scoreboard_drained", 96'(q.size()), 96'h0);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/cv32e40p_ft_fault_injector.md
# cv32e40p_ft_fault_injector

Programmable fault injector that drives per-replica bit-flip masks into the triplicated outputs of a fault-tolerant unit (aligner, compressed decoder) ahead of its voter. It is the producing end of the voter/breakage-monitor path: it schedules single, repeated or rotating replica corruptions so the voters' error flags and the breakage counters (increment/decrement/threshold) are exercised. It sits in the FT test wrapper between each replica's output and the voter input, and is configured by a testbench or debug CSR shim through a valid/ready handshake.

## Interface

- WIDTH, 32: bits per replica output; power of two, 8..64.
- DELAY_BIT, 16: width of delay and gap counters.
- COUNT_BIT, 8: width of duration, repeat and injection counters; matches the breakage-monitor counter width.
- LFSR_SEED, 32'hACE1_2468: LFSR reset value; must be nonzero.

- clk  in  1  core clock.
- rst  in  1  reset; one clock; synchronous, active-high.
- cfg_valid_i  in  1  configuration valid.
- cfg_ready_o  out  1  high only in IDLE with rst low.
- cfg_replica_i  in  2  target replica 0..2; 3 = rotate 0,1,2,0...
- cfg_mask_i  in  WIDTH  bits to flip; all-zero = one LFSR-chosen bit per injection.
- cfg_delay_i  in  DELAY_BIT  cycles from accept to first injection.
- cfg_duration_i  in  COUNT_BIT  cycles each injection is held; 0 treated as 1.
- cfg_repeat_i  in  COUNT_BIT  number of injections; 0 = unbounded until abort.
- cfg_gap_i  in  DELAY_BIT  idle cycles between injections.
- abort_i  in  1  terminate the active sequence.
- flip_mask_o  out  3*WIDTH  XOR masks; replica r in bits [r*WIDTH +: WIDTH].
- active_o  out  1  high while in INJECT.
- done_o  out  1  one-cycle pulse on natural completion.
- inj_count_o  out  COUNT_BIT  injections started since last accept; saturates at all-ones.

## Operation

- States: IDLE, DELAY, INJECT, GAP.
- Accept: cfg_valid_i & cfg_ready_o at a rising edge. All cfg fields are latched; inj_count_o and the internal repeat counter are cleared.
- IDLE -> DELAY if delay != 0; IDLE -> INJECT if delay == 0.
- DELAY: counts down the delay, then goes to INJECT.
- Entering INJECT:
  - Mask register loads cfg_mask, or 1 << lfsr[log2(WIDTH)-1:0] if cfg_mask is zero.
  - Target replica is set; in rotate mode it advances 0,1,2,0...
  - inj_count_o increments.
- INJECT lasts max(duration,1) cycles.
- On INJECT exit:
  - If repeat != 0 and injections == repeat: go to IDLE and pulse done_o.
  - Else if gap == 0: enter INJECT directly with a new mask and replica.
  - Else: go to GAP for gap cycles, then INJECT.
- flip_mask_o is nonzero only for the target replica and only in INJECT; other replicas are always 0. At most one replica is corrupted per cycle, so the voter must always mask the fault.
- abort_i in a non-IDLE state: IDLE next cycle, masks zero, no done_o. abort_i in IDLE is ignored; simultaneous abort and accept in IDLE: the accept is taken.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1. Advances every non-reset cycle.

## Timing

- All outputs are registered or decoded from registered state; there is no combinational input-to-output path except rst gating cfg_ready_o.
- Reset values: state IDLE; flip_mask_o 0, active_o 0, done_o 0, inj_count_o 0, cfg_ready_o 0 while rst is high; LFSR = LFSR_SEED.
- Accept at edge T:
  - First flip_mask_o/active_o at cycle T+1+delay.
  - Injection k starts duration'+gap cycles after injection k-1, where duration' = max(duration,1).
- done_o is high in the first IDLE cycle after the last INJECT cycle; cfg_ready_o is high in that same cycle.
- Reset mid-sequence: all of the above reset values take effect in the next cycle.
- Counters do not wrap: the delay and gap counters stop at 0, and inj_count_o holds at all-ones.

## Structure

- Add to cv32e40p_ft_pkg:
  - typedef enum finj_state_e {FINJ_IDLE, FINJ_DELAY, FINJ_INJECT, FINJ_GAP};
  - FINJ_LFSR_POLY;
  - FINJ_REPLICA_ROTATE = 2'd3.
- Sub-module cv32e40p_ft_lfsr (width, polynomial and seed parameters; enable input) holds the LFSR; the FSM and counters stay in the top module.

## Test plan

- Single shot: replica 1, mask 32'h1, delay 3, duration 2, repeat 1; accept at T.
  - flip_mask_o[63:32] = 1 at T+4..T+5; all other bits 0.
  - done_o pulse at T+6; inj_count_o = 1.
- Rotate: replica 3, mask 32'hFFFF_0000, duration 1, gap 2, repeat 4.
  - Replicas 0,1,2,0 are hit at T+1, T+4, T+7, T+10.
  - done_o at T+11.
- Back-to-back: gap 0, duration 0, repeat 3 → active_o high for 3 consecutive cycles, each a new mask and injection.
- Random bit: mask 0 → every injected mask has exactly one bit set, and the bit sequence matches a reference LFSR seeded with LFSR_SEED.
- Abort and unbounded: repeat 0 runs until abort_i.
  - Next cycle: all masks 0, state IDLE, no done_o.
  - inj_count_o holds its count, or all-ones if saturated.
- Reset: rst asserted during INJECT → next cycle outputs 0, cfg_ready_o 0 while rst is high, and 1 the cycle after rst falls.
